// File: rtl/gpio_pwm_pkg.sv
// Shared definitions for the GPIO PWM scheduler:
// register map, CTRL fields and FSM encoding.
package gpio_pwm_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_PERIOD = 4'd1;
    localparam logic [3:0] ADDR_DUTY0  = 4'd2;
    localparam logic [3:0] ADDR_CNT    = 4'd14;
    localparam logic [3:0] ADDR_STAT   = 4'd15;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_SEL_LO = 4;
    localparam int CTRL_SEL_HI = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_tick_gen.sv
// Time-base tick: clamped tap select, rising-edge detect,
// and a one-cycle blackout after any CTRL write.
module pwm_tick_gen #(
    parameter int PRESCALER = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PRESCALER-1:0] prescaler,
    input  logic [3:0]           clk_sel,
    input  logic                 ctrl_wr,
    output logic                 tick
);

    localparam int SEL_W = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(PRESCALER - 1);

    logic [SEL_W-1:0] sel;
    logic             tap;
    logic             tap_prev;
    logic             hold;

    always_comb begin
        sel = SEL_W'(clk_sel);
        if (32'(clk_sel) >= 32'(PRESCALER))
            sel = SEL_MAX;
    end

    assign tap = prescaler[sel];

    // tap_prev still reflects the old tap right after a select change
    assign tick = tap & ~tap_prev & ~hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_prev <= 1'b0;
            hold     <= 1'b0;
        end else begin
            tap_prev <= tap;
            hold     <= ctrl_wr;
        end
    end

endmodule

// File: rtl/pwm_sched_ctrl.sv
// Multi-channel PWM scheduler: register file, IDLE/LOAD/RUN
// sequencer, period counter and registered duty compare.
module pwm_sched_ctrl
    import gpio_pwm_pkg::*;
#(
    parameter int PRESCALER = 16,
    parameter int CH        = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PRESCALER-1:0] prescaler,
    input  logic                 wr_en,
    input  logic [3:0]           wr_addr,
    input  logic [CNT_W-1:0]     wr_data,
    input  logic [3:0]           rd_addr,
    output logic [CNT_W-1:0]     rd_data,
    output logic [CH-1:0]        pwm_out,
    output logic                 period_irq,
    output logic                 running
);

    state_t           state;
    state_t           state_nx;
    logic             en;
    logic [3:0]       clk_sel;
    logic [CNT_W-1:0] period_sh;
    logic [CNT_W-1:0] period_act;
    logic [CNT_W-1:0] duty_sh  [CH];
    logic [CNT_W-1:0] duty_act [CH];
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] rd_nx;
    logic [CH-1:0]    cmp;
    logic             ctrl_wr;
    logic             tick;

    assign ctrl_wr = wr_en && (wr_addr == ADDR_CTRL);
    assign running = (state == RUN);

    pwm_tick_gen #(
        .PRESCALER(PRESCALER)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .prescaler (prescaler),
        .clk_sel   (clk_sel),
        .ctrl_wr   (ctrl_wr),
        .tick      (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en        <= 1'b0;
            clk_sel   <= '0;
            period_sh <= '0;
            for (int i = 0; i < CH; i++)
                duty_sh[i] <= '0;
        end else if (wr_en) begin
            if (wr_addr == ADDR_CTRL) begin
                en      <= wr_data[CTRL_EN];
                clk_sel <= wr_data[CTRL_SEL_HI:CTRL_SEL_LO];
            end
            if (wr_addr == ADDR_PERIOD)
                period_sh <= wr_data;
            for (int i = 0; i < CH; i++)
                if (int'(wr_addr) == int'(ADDR_DUTY0) + i)
                    duty_sh[i] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en) state_nx = LOAD;
            LOAD:    state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = IDLE;
        endcase
        if (!en)
            state_nx = IDLE;
    end

    always_comb begin
        cmp = '0;
        for (int i = 0; i < CH; i++)
            cmp[i] = (cnt < duty_act[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            period_act <= '0;
            pwm_out    <= '0;
            period_irq <= 1'b0;
            for (int i = 0; i < CH; i++)
                duty_act[i] <= '0;
        end else begin
            pwm_out    <= '0;
            period_irq <= 1'b0;
            if (!en || state == IDLE) begin
                cnt <= '0;
            end else if (state == LOAD) begin
                cnt        <= '0;
                period_act <= period_sh;
                duty_act   <= duty_sh;
            end else if (state == RUN) begin
                pwm_out <= cmp;
                if (tick) begin
                    // wrap reloads from shadows as they stood before this edge
                    if (cnt == period_act) begin
                        cnt        <= '0;
                        period_act <= period_sh;
                        duty_act   <= duty_sh;
                        period_irq <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_nx = '0;
        if (rd_addr == ADDR_CTRL)
            rd_nx = CNT_W'({clk_sel, 3'b000, en});
        else if (rd_addr == ADDR_PERIOD)
            rd_nx = period_sh;
        else if (rd_addr == ADDR_CNT)
            rd_nx = cnt;
        else if (rd_addr == ADDR_STAT)
            rd_nx = CNT_W'({running, state});
        for (int i = 0; i < CH; i++)
            if (int'(rd_addr) == int'(ADDR_DUTY0) + i)
                rd_nx = duty_sh[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else
            rd_data <= rd_nx;
    end

endmodule

// File: tb/tb_pwm_sched_ctrl.sv
// Directed bench for pwm_sched_ctrl: register map, PWM timing,
// boundary duties, shadow reload, disable, tap change and reset.
module tb_pwm_sched_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] prescaler;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic [3:0]  pwm_out;
    logic        period_irq;
    logic        running;

    int errors = 0;
    int checks = 0;
    bit auto_ps = 1'b1;

    pwm_sched_ctrl #(
        .PRESCALER(16),
        .CH(4),
        .CNT_W(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .prescaler  (prescaler),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .pwm_out    (pwm_out),
        .period_irq (period_irq),
        .running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        if (auto_ps)
            prescaler = prescaler + 16'd1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        cyc();
        wr_en   = 1'b0;
    endtask

    task automatic wait_irq(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            cyc();
            if (period_irq)
                seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int n_irq;
        int n_hi;
        int k_first;
        int k_second;
        bit any_hi;
        bit all_hi;
        logic [12:0] pw;
        logic [12:0] iq;

        rst       = 1'b1;
        prescaler = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr   = '0;
        #1;
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_run", 32'(running), 32'd0);
        chk("rst_irq", 32'(period_irq), 32'd0);
        chk("rst_rd", 32'(rd_data), 32'd0);
        cyc();
        cyc();
        rst = 1'b0;

        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            cyc();
            chk($sformatf("rst_rd_%0d", a), 32'(rd_data), 32'd0);
        end

        // basic run: sel 0, PERIOD 3, DUTY0 2
        wr(4'd1, 16'd3);
        wr(4'd2, 16'd2);
        rd_addr = 4'd1;
        cyc();
        chk("rd_period", 32'(rd_data), 32'd3);
        wr(4'd0, 16'h0001);
        chk("run_k0", 32'(running), 32'd0);
        cyc();
        chk("run_k1", 32'(running), 32'd0);
        cyc();
        chk("run_k2", 32'(running), 32'd1);
        repeat (4) cyc();
        n_irq = 0;
        n_hi = 0;
        k_first = -1;
        k_second = -1;
        for (int k = 0; k < 16; k++) begin
            cyc();
            if (pwm_out[0])
                n_hi++;
            if (period_irq) begin
                n_irq++;
                if (k_first < 0)
                    k_first = k;
                else if (k_second < 0)
                    k_second = k;
            end
        end
        chk("basic_irq_cnt", 32'(n_irq), 32'd2);
        chk("basic_pwm_hi", 32'(n_hi), 32'd8);
        chk("basic_irq_gap", 32'(k_second - k_first), 32'd8);

        // boundaries: PERIOD 4, DUTY1 0, DUTY2 7
        wr(4'd1, 16'd4);
        wr(4'd3, 16'd0);
        wr(4'd4, 16'd7);
        wait_irq("bnd_wrap");
        cyc();
        n_irq = 0;
        n_hi = 0;
        any_hi = 1'b0;
        all_hi = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (period_irq)
                n_irq++;
            if (pwm_out[0])
                n_hi++;
            if (pwm_out[1])
                any_hi = 1'b1;
            if (!pwm_out[2])
                all_hi = 1'b0;
        end
        chk("duty0_zero_low", 32'(any_hi), 32'd0);
        chk("duty_gt_per_high", 32'(all_hi), 32'd1);
        chk("p4_irq_cnt", 32'(n_irq), 32'd1);
        chk("p4_pwm0_hi", 32'(n_hi), 32'd4);

        // PERIOD 0: every tick wraps
        wr(4'd1, 16'd0);
        wait_irq("p0_wrap");
        cyc();
        n_irq = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (period_irq)
                n_irq++;
        end
        chk("p0_irq_cnt", 32'(n_irq), 32'd4);
        chk("p0_pwm", 32'(pwm_out), 32'h5);

        // mid-period duty reload at counter 1
        wr(4'd1, 16'd3);
        wait_irq("mid_wrap");
        pw = '0;
        iq = '0;
        cyc();
        cyc();
        rd_addr = 4'd14;
        wr(4'd2, 16'd1);
        pw[3] = pwm_out[0];
        iq[3] = period_irq;
        for (int k = 4; k <= 12; k++) begin
            cyc();
            pw[k] = pwm_out[0];
            iq[k] = period_irq;
        end
        chk("mid_pwm_seq", 32'(pw[12:3]), 32'b0011000011);
        chk("mid_irq_seq", 32'(iq[12:3]), 32'b0000100000);
        chk("mid_cnt", 32'(rd_data), 32'd1);

        // disable with counter at 2
        wr(4'd0, 16'h0000);
        chk("dis_k1_run", 32'(running), 32'd1);
        chk("dis_k1_pwm", 32'(pwm_out), 32'h4);
        chk("dis_k1_cnt", 32'(rd_data), 32'd2);
        cyc();
        chk("dis_k2_pwm", 32'(pwm_out), 32'd0);
        chk("dis_k2_run", 32'(running), 32'd0);
        chk("dis_k2_irq", 32'(period_irq), 32'd0);
        cyc();
        chk("dis_k3_cnt", 32'(rd_data), 32'd0);
        chk("dis_k3_irq", 32'(period_irq), 32'd0);

        // re-enable passes through LOAD
        rd_addr = 4'd15;
        wr(4'd0, 16'h0001);
        cyc();
        cyc();
        chk("re_stat_load", 32'(rd_data), 32'd1);
        cyc();
        chk("re_stat_run", 32'(rd_data), 32'd6);
        rd_addr = 4'd14;
        cyc();
        chk("re_cnt0", 32'(rd_data), 32'd0);
        cyc();
        chk("re_cnt1", 32'(rd_data), 32'd1);

        // tap change 0 -> 5 while bit 5 is high
        wr(4'd1, 16'd0);
        wait_irq("tap_p0_wrap");
        auto_ps = 1'b0;
        prescaler = 16'h0020;
        n_irq = 0;
        repeat (3) begin
            cyc();
            if (period_irq)
                n_irq++;
        end
        chk("tap_idle_irq", 32'(n_irq), 32'd0);
        wr(4'd0, 16'h0051);
        n_irq = 0;
        repeat (4) begin
            if (period_irq)
                n_irq++;
            cyc();
        end
        chk("tap_switch_no_tick", 32'(n_irq), 32'd0);
        prescaler = 16'h0000;
        cyc();
        cyc();
        prescaler = 16'h0020;
        cyc();
        chk("tap5_rise", 32'(period_irq), 32'd1);
        cyc();
        chk("tap5_single", 32'(period_irq), 32'd0);

        // clk_sel 15
        wr(4'd0, 16'h00F1);
        rd_addr = 4'd0;
        cyc();
        chk("ctrl_sel15", 32'(rd_data), 32'h00F1);
        cyc();
        prescaler = 16'h8000;
        cyc();
        chk("tap15_rise", 32'(period_irq), 32'd1);
        cyc();
        chk("pre_rst_pwm", 32'(pwm_out), 32'h5);

        // asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pwm", 32'(pwm_out), 32'd0);
        chk("arst_run", 32'(running), 32'd0);
        chk("arst_rd", 32'(rd_data), 32'd0);
        cyc();
        rst = 1'b0;
        rd_addr = 4'd15;
        cyc();
        chk("arst_stat", 32'(rd_data), 32'd0);
        rd_addr = 4'd0;
        cyc();
        chk("arst_ctrl", 32'(rd_data), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
